// File: rtl/matrix_mac_sequencer_if.sv
// Bus bundle for matrix_mac_sequencer.
//   start/abort            : control requests into the sequencer
//   a_addr/a_data          : A store read port (combinational read)
//   b_addr/b_data          : B store read port (combinational read)
//   mac_entry1/2, mac_sum  : operands to the external MAC
//   mac_new_sum, mac_c15   : MAC result and carry-out
//   c_we/c_addr/c_data/c_ovf : C store write port
//   busy/done              : status
// slave modport is the sequencer side; master is the environment side.
interface matrix_mac_sequencer_if;
    logic        start;
    logic        abort;
    logic [3:0]  a_addr;
    logic [7:0]  a_data;
    logic [3:0]  b_addr;
    logic [7:0]  b_data;
    logic [7:0]  mac_entry1;
    logic [7:0]  mac_entry2;
    logic [15:0] mac_sum;
    logic [15:0] mac_new_sum;
    logic        mac_c15;
    logic        c_we;
    logic [3:0]  c_addr;
    logic [15:0] c_data;
    logic        c_ovf;
    logic        busy;
    logic        done;

    modport slave (
        input  start, abort, a_data, b_data, mac_new_sum, mac_c15,
        output a_addr, b_addr, mac_entry1, mac_entry2, mac_sum,
               c_we, c_addr, c_data, c_ovf, busy, done
    );

    modport master (
        output start, abort, a_data, b_data, mac_new_sum, mac_c15,
        input  a_addr, b_addr, mac_entry1, mac_entry2, mac_sum,
               c_we, c_addr, c_data, c_ovf, busy, done
    );
endinterface

// File: rtl/matrix_mac_sequencer.sv
// Sequences C = A x B over NxN row-major matrices (N = 2..4) using an
// external combinational MAC. One MAC step per cycle per inner index k,
// then one WRITE cycle per C element, then a one-cycle DONE pulse.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : matrix_mac_sequencer_if.slave (control, A/B reads, MAC, C write, status)
module matrix_mac_sequencer #(
    parameter int unsigned N = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    matrix_mac_sequencer_if.slave         bus
);

    localparam logic [1:0] LAST = 2'(N - 1);
    localparam logic [3:0] DIM  = 4'(N);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  i, j, k;
    logic [15:0] acc;
    logic        ovf;

    logic [3:0]  a_idx, b_idx, c_idx;

    assign a_idx = {2'b00, i} * DIM + {2'b00, k};
    assign b_idx = {2'b00, k} * DIM + {2'b00, j};
    assign c_idx = {2'b00, i} * DIM + {2'b00, j};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort wins over both start and WRITE advance
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_MAC;
            ST_MAC: begin
                if (bus.abort)      state_nxt = ST_IDLE;
                else if (k == LAST) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.abort)                       state_nxt = ST_IDLE;
                else if (i == LAST && j == LAST)     state_nxt = ST_DONE;
                else                                 state_nxt = ST_MAC;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Index / accumulator datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                        ovf <= 1'b0;
                    end
                end
                ST_MAC: begin
                    if (!bus.abort) begin
                        acc <= bus.mac_new_sum;
                        ovf <= ovf | bus.mac_c15;
                        if (k != LAST) k <= k + 2'd1;
                    end
                end
                ST_WRITE: begin
                    acc <= '0;
                    ovf <= 1'b0;
                    k   <= '0;
                    if (!bus.abort) begin
                        if (j != LAST) begin
                            j <= j + 2'd1;
                        end else if (i != LAST) begin
                            j <= '0;
                            i <= i + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mac_entry1 = bus.a_data;
    assign bus.mac_entry2 = bus.b_data;

    // Outputs are state-decoded so every bus signal is zero outside its phase
    always_comb begin
        bus.a_addr  = '0;
        bus.b_addr  = '0;
        bus.mac_sum = '0;
        bus.c_we    = 1'b0;
        bus.c_addr  = '0;
        bus.c_data  = '0;
        bus.c_ovf   = 1'b0;
        bus.busy    = (state != ST_IDLE);
        bus.done    = (state == ST_DONE);
        case (state)
            ST_MAC: begin
                bus.a_addr  = a_idx;
                bus.b_addr  = b_idx;
                bus.mac_sum = acc;
            end
            ST_WRITE: begin
                bus.c_we   = 1'b1;
                bus.c_addr = c_idx;
                bus.c_data = acc;
                bus.c_ovf  = ovf;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Directed bench: an N=2 and an N=4 sequencer, each with A/B stores and a
// behavioural MAC; checks every cycle against hand-derived timelines.
module tb_matrix_mac_sequencer;

    logic clk;
    logic rst_n;

    matrix_mac_sequencer_if if2 ();
    matrix_mac_sequencer_if if4 ();

    matrix_mac_sequencer #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    matrix_mac_sequencer #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    logic [7:0]  a2 [16];
    logic [7:0]  b2 [16];
    logic [7:0]  a4 [16];
    logic [7:0]  b4 [16];
    logic [15:0] exp_c [4];
    logic        exp_ovf;

    logic [16:0] full2, full4;

    assign if2.a_data = a2[if2.a_addr];
    assign if2.b_data = b2[if2.b_addr];
    assign full2 = 17'({8'd0, if2.mac_entry1} * {8'd0, if2.mac_entry2}) + {1'b0, if2.mac_sum};
    assign if2.mac_new_sum = full2[15:0];
    assign if2.mac_c15     = full2[16];

    assign if4.a_data = a4[if4.a_addr];
    assign if4.b_data = b4[if4.b_addr];
    assign full4 = 17'({8'd0, if4.mac_entry1} * {8'd0, if4.mac_entry2}) + {1'b0, if4.mac_sum};
    assign if4.mac_new_sum = full4[15:0];
    assign if4.mac_c15     = full4[16];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    endtask

    task automatic check_idle2(input string tag);
        check({tag, " busy"},   32'(if2.busy),   32'd0);
        check({tag, " done"},   32'(if2.done),   32'd0);
        check({tag, " c_we"},   32'(if2.c_we),   32'd0);
        check({tag, " c_ovf"},  32'(if2.c_ovf),  32'd0);
        check({tag, " c_addr"}, 32'(if2.c_addr), 32'd0);
        check({tag, " c_data"}, 32'(if2.c_data), 32'd0);
        check({tag, " a_addr"}, 32'(if2.a_addr), 32'd0);
        check({tag, " b_addr"}, 32'(if2.b_addr), 32'd0);
        check({tag, " sum"},    32'(if2.mac_sum), 32'd0);
    endtask

    // One N=2 run. Called at a negedge; start is raised here and the
    // following posedge is edge E. stop_cyc injects abort (use_abort=1)
    // or reset (use_abort=0) during that cycle; 0 = none.
    task automatic run2(input string tag, input int unsigned stop_cyc,
                        input bit use_abort, input int unsigned restart_cyc);
        bit          active, wr;
        int unsigned e;
        if2.start = 1'b1;
        for (int unsigned cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            active = (stop_cyc == 0) || (cyc <= stop_cyc);
            wr     = active && (cyc % 3 == 0) && (cyc <= 12);
            e      = wr ? (cyc / 3 - 1) : 0;
            check($sformatf("%s busy@%0d", tag, cyc), 32'(if2.busy), 32'(active && cyc <= 13));
            check($sformatf("%s done@%0d", tag, cyc), 32'(if2.done), 32'(active && cyc == 13));
            check($sformatf("%s c_we@%0d", tag, cyc), 32'(if2.c_we), 32'(wr));
            check($sformatf("%s c_addr@%0d", tag, cyc), 32'(if2.c_addr), wr ? 32'(e) : 32'd0);
            check($sformatf("%s c_data@%0d", tag, cyc), 32'(if2.c_data), wr ? 32'(exp_c[e]) : 32'd0);
            check($sformatf("%s c_ovf@%0d", tag, cyc), 32'(if2.c_ovf), wr ? 32'(exp_ovf) : 32'd0);
            if (cyc == 2 && active) begin
                check($sformatf("%s a_addr@2", tag), 32'(if2.a_addr), 32'd1);
                check($sformatf("%s b_addr@2", tag), 32'(if2.b_addr), 32'd2);
                check($sformatf("%s sum@2", tag), 32'(if2.mac_sum), 32'(a2[0]) * 32'(b2[0]));
                check($sformatf("%s entry1@2", tag), 32'(if2.mac_entry1), 32'(a2[1]));
            end
            if2.start = (cyc == restart_cyc);
            if2.abort = use_abort && (cyc == stop_cyc);
            rst_n     = !(!use_abort && cyc == stop_cyc);
        end
        if2.start = 1'b0;
        if2.abort = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic load_ab(input logic [7:0] a0, a1, a2_, a3, b0, b1, b2_, b3);
        a2[0] = a0; a2[1] = a1; a2[2] = a2_; a2[3] = a3;
        b2[0] = b0; b2[1] = b1; b2[2] = b2_; b2[3] = b3;
    endtask

    initial begin
        bit wr;
        for (int i = 0; i < 16; i++) begin
            a2[i] = '0; b2[i] = '0; a4[i] = 8'd1; b4[i] = 8'd1;
        end
        if2.start = 1'b0; if2.abort = 1'b0;
        if4.start = 1'b0; if4.abort = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Start held with reset: reset must win
        if2.start = 1'b1;
        @(negedge clk);
        check_idle2("reset");
        check("reset4 busy", 32'(if4.busy), 32'd0);
        check("reset4 c_we", 32'(if4.c_we), 32'd0);
        if2.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle2("post-reset");

        // Basic product
        load_ab(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        exp_c[0] = 16'd19; exp_c[1] = 16'd22; exp_c[2] = 16'd43; exp_c[3] = 16'd50;
        exp_ovf = 1'b0;
        run2("basic", 0, 1'b0, 0);

        // Wrapping accumulation: 2*65025 mod 65536
        load_ab(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
        for (int i = 0; i < 4; i++) exp_c[i] = 16'd64514;
        exp_ovf = 1'b1;
        run2("wrap", 0, 1'b0, 0);

        // Identity with a start mid-run that must be ignored
        load_ab(8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6);
        exp_c[0] = 16'd9; exp_c[1] = 16'd8; exp_c[2] = 16'd7; exp_c[3] = 16'd6;
        exp_ovf = 1'b0;
        run2("ident", 0, 1'b0, 5);

        // Reset mid-run, then a clean rerun
        load_ab(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        exp_c[0] = 16'd19; exp_c[1] = 16'd22; exp_c[2] = 16'd43; exp_c[3] = 16'd50;
        run2("rst", 7, 1'b0, 0);
        check_idle2("after-rst");
        run2("rerun", 0, 1'b0, 0);

        // Abort during the second element's MAC
        run2("abort", 4, 1'b1, 0);
        check_idle2("after-abort");

        // Abort while idle is ignored
        if2.abort = 1'b1;
        @(negedge clk);
        if2.abort = 1'b0;
        check_idle2("idle-abort");

        // N=4 all-ones
        if4.start = 1'b1;
        for (int unsigned cyc = 1; cyc <= 83; cyc++) begin
            @(negedge clk);
            if4.start = 1'b0;
            wr = (cyc % 5 == 0) && (cyc <= 80);
            check($sformatf("n4 c_we@%0d", cyc), 32'(if4.c_we), 32'(wr));
            check($sformatf("n4 done@%0d", cyc), 32'(if4.done), 32'(cyc == 81));
            check($sformatf("n4 busy@%0d", cyc), 32'(if4.busy), 32'(cyc <= 81));
            if (wr) begin
                check($sformatf("n4 c_addr@%0d", cyc), 32'(if4.c_addr), 32'(cyc / 5 - 1));
                check($sformatf("n4 c_data@%0d", cyc), 32'(if4.c_data), 32'd4);
                check($sformatf("n4 c_ovf@%0d", cyc), 32'(if4.c_ovf), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matrix_mac_sequencer.md
MATRIX_MAC_SEQUENCER -- requirements
Module: matrix_mac_sequencer

Interface
REQ-001 Parameter N, default 2, matrix dimension (legal 2..4); square NxN matrices A, B, C, row-major, address = row*N + col.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low; sampled on rising clk.
REQ-004 start  in  1  one-cycle request to compute C = A x B; honoured only in IDLE.
REQ-005 abort  in  1  terminates a running computation.
REQ-006 a_addr  out  4  read address into A store; a_data returns same cycle (combinational read).
REQ-007 a_data  in  8  unsigned A element.
REQ-008 b_addr  out  4  read address into B store; combinational read.
REQ-009 b_data  in  8  unsigned B element.
REQ-010 mac_entry1  out  8  to MAC multiplicand, equals a_data.
REQ-011 mac_entry2  out  8  to MAC multiplier, equals b_data.
REQ-012 mac_sum  out  16  to MAC addend, equals internal accumulator.
REQ-013 mac_new_sum  in  16  MAC result, entry1*entry2 + sum, low 16 bits, combinational.
REQ-014 mac_c15  in  1  MAC carry-out, high when the 16-bit result wrapped.
REQ-015 c_we  out  1  one-cycle write strobe for C store.
REQ-016 c_addr  out  4  C write address, valid when c_we.
REQ-017 c_data  out  16  C element, valid when c_we.
REQ-018 c_ovf  out  1  high with c_we when any MAC step of that element carried out.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse at completion.

Function
REQ-021 States: IDLE, MAC, WRITE, DONE; indices i (row), j (col), k (inner), each 0..N-1; 16-bit accumulator acc; 1-bit sticky ovf.
REQ-022 IDLE: start=1 -> MAC with i=j=k=0, acc=0, ovf=0; start=0 -> stay.
REQ-023 MAC: a_addr=i*N+k, b_addr=k*N+j; at edge acc<=mac_new_sum, ovf<=ovf|mac_c15; k<N-1 -> k+1, stay; k=N-1 -> WRITE.
REQ-024 WRITE: c_we=1, c_addr=i*N+j, c_data=acc, c_ovf=ovf for exactly one cycle; then acc<=0, ovf<=0, k<=0.
REQ-025 WRITE advance: j<N-1 -> j+1, MAC; j=N-1,i<N-1 -> j=0, i+1, MAC; i=j=N-1 -> DONE.
REQ-026 DONE: done=1 one cycle, then IDLE.
REQ-027 Latency: start sampled at edge E -> first MAC cycle E+1; element (i,j) written in cycle (i*N+j+1)*(N+1) after E; done high in cycle N*N*(N+1)+1 after E (N=2: 13).
REQ-028 Arithmetic: accumulation wraps modulo 2^16; no saturation; c_ovf reports any wrap during that element.
REQ-029 start while busy ignored, no effect on indices or outputs.
REQ-030 abort=1 in MAC or WRITE -> IDLE next edge; no c_we in that edge's cycle if in MAC; no done; abort has priority over start and over a coincident WRITE-advance; abort in IDLE or DONE ignored (DONE still pulses).
REQ-031 Outside MAC, a_addr, b_addr, mac_sum drive 0; outside WRITE, c_we=0, c_addr=0, c_data=0, c_ovf=0.
REQ-032 c_we pulses exactly N*N times per non-aborted run, addresses strictly ascending 0..N*N-1.

Reset
REQ-033 rst_n=0 at an edge -> IDLE, i=j=k=0, acc=0, ovf=0 regardless of state; highest priority over start and abort.
REQ-034 Outputs during and after reset until next start: busy=0, done=0, c_we=0, c_ovf=0, all addresses and data 0.
REQ-035 Reset mid-operation discards partial results; no further c_we or done from the interrupted run.

Verification
REQ-036 N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> c_we at cycles 3,6,9,12 with (addr,data)=(0,19),(1,22),(2,43),(3,50), c_ovf=0, done at cycle 13, busy 0 at 14.
REQ-037 N=2, all A and B elements 255 -> every c_data=64514, c_ovf=1.
REQ-038 N=2, A=identity, B=[[9,8],[7,6]] -> C writes 9,8,7,6; then start during run at cycle 5 -> ignored, done still at cycle 13.
REQ-039 N=2 run, rst_n=0 at cycle 7 -> IDLE next edge, busy=0, no further c_we, no done; new start completes normally with correct C.
REQ-040 N=2 run, abort=1 at cycle 4 -> exactly one c_we (addr 0) seen, busy=0 next cycle, done never asserted.
REQ-041 N=4, A=B=all 1 -> 16 writes, each c_data=4, addresses 0..15, done at cycle 81.
